top_job_sequencer: RTL and testbench

TOP_JOB_SEQUENCER -- requirements
Module: top_job_sequencer

---
 rtl/top_job_sequencer_if.sv | 36 +++
 rtl/top_job_sequencer.sv | 176 +++++++++++++++++
 tb/tb_top_job_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/top_job_sequencer_if.sv
// Job sequencer bus: job offer, top broadcast, bot request and result return.
interface top_job_sequencer_if #(
  parameter int unsigned COUNT_W = 32
);
  localparam int unsigned TOP_W = 128;

  logic [TOP_W-1:0]   jobTop;
  logic [COUNT_W-1:0] jobBotCount;
  logic               jobValid;
  logic               jobReady;
  logic [TOP_W-1:0]   topOut;
  logic               topOutValid;
  logic               topStall;
  logic               botValid;
  logic [COUNT_W-1:0] botIndex;
  logic               botReady;
  logic               resultValid;
  logic               jobDone;
  logic [COUNT_W-1:0] jobDoneCount;
  logic               idle;
  logic               protocolError;

  // Sequencer side
  modport slave (
    input  jobTop, jobBotCount, jobValid, topStall, botReady, resultValid,
    output jobReady, topOut, topOutValid, botValid, botIndex,
           jobDone, jobDoneCount, idle, protocolError
  );

  // Job source / topManager / pipeline side
  modport master (
    output jobTop, jobBotCount, jobValid, topStall, botReady, resultValid,
    input  jobReady, topOut, topOutValid, botValid, botIndex,
           jobDone, jobDoneCount, idle, protocolError
  );
endinterface

// File: rtl/top_job_sequencer.sv
// Job sequencer: loads a job's top into the topManager, issues the job's bots
// in ascending order under an in-flight limit, and reports job completion.
module top_job_sequencer #(
  parameter int unsigned MAX_IN_FLIGHT = 512,
  parameter int unsigned COUNT_W       = 32
) (
  input logic                 clk,
  input logic                 rst,
  top_job_sequencer_if.slave  bus
);

  localparam int unsigned TOP_W = 128;
  // Wide enough to hold both any count and MAX_IN_FLIGHT (up to 65535)
  localparam int unsigned CMP_W = (COUNT_W > 17) ? COUNT_W + 1 : 18;

  typedef enum logic [2:0] {
    IDLE,
    SEND_TOP,
    WAIT_STALL,
    WAIT_LOAD,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TOP_W-1:0]   top_q, top_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] issued_q, issued_d;
  logic [COUNT_W-1:0] returned_q, returned_d;
  logic               err_q, err_d;

  logic               job_ready_q;
  logic               idle_q;
  logic [TOP_W-1:0]   top_out_q;
  logic               top_out_valid_q;
  logic               bot_valid_q, bot_valid_d;
  logic [COUNT_W-1:0] bot_index_q;
  logic               job_done_q;
  logic [COUNT_W-1:0] job_done_count_q;

  logic [COUNT_W-1:0] in_flight;
  logic [COUNT_W-1:0] in_flight_d;
  logic               bot_fire;
  logic               result_ok;
  logic               result_bad;

  // Handshake qualification; a result is only legal while bots are outstanding
  always_comb begin
    in_flight  = issued_q - returned_q;
    bot_fire   = bot_valid_q && bus.botReady;
    result_ok  = bus.resultValid && (in_flight != '0) &&
                 ((state_q == ISSUE) || (state_q == DRAIN));
    result_bad = bus.resultValid && !result_ok;
  end

  // Next-state and counter update
  always_comb begin
    state_d     = state_q;
    top_d       = top_q;
    count_d     = count_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    err_d       = err_q | result_bad;
    bot_valid_d = 1'b0;
    in_flight_d = '0;

    if (result_ok) begin
      returned_d = returned_q + COUNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.jobValid && job_ready_q) begin
          top_d   = bus.jobTop;
          count_d = bus.jobBotCount;
          state_d = (bus.jobBotCount == '0) ? DONE : SEND_TOP;
        end
      end
      SEND_TOP: begin
        state_d = WAIT_STALL;
      end
      WAIT_STALL: begin
        if (bus.topStall) begin
          state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (!bus.topStall) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bot_fire) begin
          issued_d = issued_q + COUNT_W'(1);
          if (issued_d == count_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (returned_d == count_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d    = IDLE;
        issued_d   = '0;
        returned_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Request is offered only while below both the job size and the in-flight cap
    in_flight_d = issued_d - returned_d;
    bot_valid_d = (state_d == ISSUE) && (issued_d < count_d) &&
                  (CMP_W'(in_flight_d) < CMP_W'(MAX_IN_FLIGHT));
  end

  // State and job bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      top_q      <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_q      <= top_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      err_q      <= err_d;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      job_ready_q      <= 1'b1;
      idle_q           <= 1'b1;
      top_out_q        <= '0;
      top_out_valid_q  <= 1'b0;
      bot_valid_q      <= 1'b0;
      bot_index_q      <= '0;
      job_done_q       <= 1'b0;
      job_done_count_q <= '0;
    end else begin
      job_ready_q      <= (state_d == IDLE);
      idle_q           <= (state_d == IDLE);
      top_out_valid_q  <= (state_d == SEND_TOP);
      if (state_d == SEND_TOP) begin
        top_out_q <= top_d;
      end
      bot_valid_q      <= bot_valid_d;
      bot_index_q      <= issued_d;
      job_done_q       <= (state_d == DONE);
      job_done_count_q <= (state_d == DONE) ? count_d : '0;
    end
  end

  assign bus.jobReady      = job_ready_q;
  assign bus.idle          = idle_q;
  assign bus.topOut        = top_out_q;
  assign bus.topOutValid   = top_out_valid_q;
  assign bus.botValid      = bot_valid_q;
  assign bus.botIndex      = bot_index_q;
  assign bus.jobDone       = job_done_q;
  assign bus.jobDoneCount  = job_done_count_q;
  assign bus.protocolError = err_q;

endmodule

// File: tb/tb_top_job_sequencer.sv
// Bench for top_job_sequencer: random bot acceptance and result latency
// checked against a transaction-level model of a job's life.
module tb_top_job_sequencer;

  localparam int unsigned MAXF = 2;
  localparam int unsigned CW   = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  top_job_sequencer_if #(.COUNT_W(CW)) bus ();

  top_job_sequencer #(
    .MAX_IN_FLIGHT(MAXF),
    .COUNT_W      (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One job from offer to completion. Model: bots leave in index order while
  // the topManager has finished loading, the job is not fully issued, and
  // fewer than MAXF results are outstanding; each result returns after a
  // random latency; completion comes after the last result.
  task automatic run_job(input logic [127:0] top, input int cnt, input int dmin,
                         input int dmax, input int rdy_pct, input int stall_len,
                         input int abort_n);
    int  issued_m   = 0;
    int  returned_m = 0;
    int  strobes    = 0;
    int  dones      = 0;
    int  stall_left = 0;
    int  cyc        = 0;
    int  done_cyc   = -1;
    bit  loaded     = 1'b0;
    bit  finished   = 1'b0;
    bit  exp_bv;
    bit  rv;
    bit  br;
    int  pend[$];
    logic [CW-1:0] cnt_v;
    cnt_v = CW'(cnt);

    check("ready_before_job", bus.jobReady, 1'b1);
    bus.jobTop      = top;
    bus.jobBotCount = cnt_v;
    bus.jobValid    = 1'b1;

    while (!finished && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      bus.jobValid = 1'b0;

      exp_bv = loaded && (issued_m < cnt) && ((issued_m - returned_m) < int'(MAXF));
      check("botValid", bus.botValid, exp_bv);
      if (bus.botValid) check("botIndex", bus.botIndex, issued_m);
      check("jobReady_busy", bus.jobReady, 1'b0);
      if (bus.topOutValid) begin
        strobes++;
        check("topOut", bus.topOut, top);
      end
      if (bus.jobDone) begin
        dones++;
        done_cyc = cyc;
        check("jobDoneCount", bus.jobDoneCount, cnt_v);
        check("returned_at_done", returned_m, cnt);
        check("issued_at_done", issued_m, cnt);
        finished = 1'b1;
      end

      // topManager: raise stall after the strobe, hold it, then finish loading
      if (bus.topOutValid) begin
        stall_left   = stall_len;
        bus.topStall = 1'b1;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          bus.topStall = 1'b0;
          loaded       = 1'b1;
        end
      end

      // Pipeline returns at most one result per cycle
      foreach (pend[i]) pend[i]--;
      rv = 1'b0;
      foreach (pend[i]) begin
        if (!rv && pend[i] <= 0) begin
          pend.delete(i);
          rv = 1'b1;
          returned_m++;
          break;
        end
      end
      bus.resultValid = rv;

      if (abort_n > 0 && issued_m >= abort_n) begin
        // Reset must win over a job offer, a result and a bot accept
        rst             = 1'b1;
        bus.jobValid    = 1'b1;
        bus.resultValid = 1'b1;
        bus.botReady    = 1'b1;
        @(negedge clk);
        check("abort_idle", bus.idle, 1'b1);
        check("abort_botValid", bus.botValid, 1'b0);
        check("abort_jobDone", bus.jobDone, 1'b0);
        check("abort_jobReady", bus.jobReady, 1'b1);
        check("abort_topOut", bus.topOut, 128'h0);
        check("abort_botIndex", bus.botIndex, 0);
        check("abort_error", bus.protocolError, 1'b0);
        rst             = 1'b0;
        bus.jobValid    = 1'b0;
        bus.resultValid = 1'b0;
        bus.botReady    = 1'b0;
        bus.topStall    = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", bus.jobDone, 1'b0);
          check("abort_stays_idle", bus.idle, 1'b1);
        end
        return;
      end

      br = ($urandom_range(0, 99) < rdy_pct);
      bus.botReady = br;
      if (br && bus.botValid) begin
        issued_m++;
        pend.push_back(int'($urandom_range(dmin, dmax)));
      end

      if (finished) begin
        bus.botReady    = 1'b0;
        bus.resultValid = 1'b0;
        bus.topStall    = 1'b0;
      end
    end

    check("job_completed", finished, 1'b1);
    if (finished) begin
      @(negedge clk);
      check("done_one_cycle", bus.jobDone, 1'b0);
      check("ready_after_done", bus.jobReady, 1'b1);
      check("idle_after_done", bus.idle, 1'b1);
    end
    check("top_strobes", strobes, (cnt != 0) ? 1 : 0);
    check("done_pulses", dones, 1);
    check("all_indices_issued", issued_m, cnt);
    check("no_error", bus.protocolError, 1'b0);
    if (cnt == 0) check("zero_done_latency", (done_cyc >= 1) && (done_cyc <= 2), 1'b1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.jobTop      = '0;
    bus.jobBotCount = '0;
    bus.jobValid    = 1'b0;
    bus.topStall    = 1'b0;
    bus.botReady    = 1'b0;
    bus.resultValid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_jobReady", bus.jobReady, 1'b1);
    check("rst_idle", bus.idle, 1'b1);
    check("rst_topOutValid", bus.topOutValid, 1'b0);
    check("rst_botValid", bus.botValid, 1'b0);
    check("rst_jobDone", bus.jobDone, 1'b0);
    check("rst_topOut", bus.topOut, 128'h0);
    check("rst_botIndex", bus.botIndex, 0);
    check("rst_jobDoneCount", bus.jobDoneCount, 0);
    check("rst_error", bus.protocolError, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic job with a five-cycle topManager load
    run_job({16{8'hA5}}, 4, 1, 3, 100, 5, 0);
    // Slow results against the in-flight cap
    run_job(128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 6, 10, 10, 100, 3, 0);
    // Random bot acceptance
    run_job({4{$urandom}}, 20, 1, 8, 50, 3, 0);
    run_job({4{$urandom}}, 12, 1, 3, 70, 2, 0);
    // Empty job
    run_job(128'hdead_beef, 0, 1, 1, 100, 2, 0);
    // Back-to-back jobs
    run_job({4{$urandom}}, 3, 1, 4, 80, 2, 0);
    run_job({4{$urandom}}, 5, 1, 4, 80, 2, 0);
    // Largest representable count
    run_job({4{$urandom}}, 255, 1, 2, 90, 2, 0);
    // Reset in the middle of issuing
    run_job({4{$urandom}}, 10, 20, 20, 100, 2, 3);

    // Stray result while idle is flagged, ignored, and sticky until reset
    bus.resultValid = 1'b1;
    @(negedge clk);
    bus.resultValid = 1'b0;
    @(negedge clk);
    check("stray_result_error", bus.protocolError, 1'b1);
    check("stray_result_idle", bus.idle, 1'b1);
    repeat (4) @(negedge clk);
    check("error_sticky", bus.protocolError, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("error_cleared", bus.protocolError, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
